// File: rtl/bram_pkg.sv
// bram_pkg: shared types and constants for the single-port block RAM controller
package bram_pkg;
    typedef enum logic {CLEAR, READY} bram_state_e;
    typedef enum logic {READ_FIRST, WRITE_FIRST} bram_wmode_e;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/bram_sp_core.sv
// bram_sp_core: storage array with byte-enable merge and the first read register
module bram_sp_core
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int WRITE_MODE = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         wen,
    input  logic                         load,
    input  logic [DATA_WIDTH/BYTE_W-1:0] be,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]        datai,
    output logic [DATA_WIDTH-1:0]        rdata
);
    localparam int NB = DATA_WIDTH / BYTE_W;
    localparam bit WF = (WRITE_MODE == int'(WRITE_FIRST));
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    assign old_word = mem[addr];
    // Overlay enabled bytes of the write data onto the currently stored word
    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++)
            if (be[i]) merged[i*BYTE_W +: BYTE_W] = datai[i*BYTE_W +: BYTE_W];
    end
    // Array write port; contents are left unreset so the array maps onto block RAM
    always_ff @(posedge clk)
        if (en && wen) mem[addr] <= merged;
    // First return register, loaded only for accepted requests so it holds between returns
    always_ff @(posedge clk or negedge reset)
        if (!reset) rdata <= '0;
        else if (load) rdata <= (WF && wen) ? merged : old_word;
endmodule

// File: rtl/bram_sp_ctrl.sv
// bram_sp_ctrl: single-port block RAM with request/valid handshake and post-reset clear sweep
module bram_sp_ctrl
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bram_en,
    input  logic                         bram_wen,
    input  logic [DATA_WIDTH/BYTE_W-1:0] bram_be,
    input  logic [ADDR_WIDTH-1:0]        bram_addr,
    input  logic [DATA_WIDTH-1:0]        bram_datai,
    output logic [DATA_WIDTH-1:0]        bram_datao,
    output logic                         bram_rvalid,
    output logic                         bram_ready
);
    if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
        $error("bram_sp_ctrl: DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_sp_ctrl: READ_LATENCY must be 1 or 2");
    end
    bram_state_e           state, state_nx;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clearing;
    logic                  accept;
    logic                  v1;
    logic [DATA_WIDTH-1:0] core_rdata;
    assign accept = bram_en & bram_ready;
    // State register and sweep address, restarting the sweep on every reset
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_addr <= '0;
        end else begin
            state <= state_nx;
            if (clearing) clr_addr <= clr_addr + 1'b1;
        end
    // Sweep until the last word has been zeroed, then accept traffic for good
    always_comb begin
        state_nx   = state;
        clearing   = 1'b0;
        bram_ready = 1'b0;
        if (state == CLEAR) begin
            clearing = 1'b1;
            if (clr_addr == '1) state_nx = READY;
        end else begin
            bram_ready = 1'b1;
        end
    end
    bram_sp_core #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .WRITE_MODE(WRITE_MODE)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .en   (clearing | accept),
        .wen  (clearing | bram_wen),
        .load (accept),
        .be   (clearing ? '1 : bram_be),
        .addr (clearing ? clr_addr : bram_addr),
        .datai(clearing ? '0 : bram_datai),
        .rdata(core_rdata)
    );
    // First-stage valid tracks which core register loads carry a return
    always_ff @(posedge clk or negedge reset)
        if (!reset) v1 <= 1'b0;
        else v1 <= accept;
    if (READ_LATENCY == 2) begin : g_lat2
        logic                  v2;
        logic [DATA_WIDTH-1:0] d2;
        // Output pipeline stage, advancing data only alongside a valid return
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= core_rdata;
            end
        assign bram_rvalid = v2;
        assign bram_datao  = d2;
    end else begin : g_lat1
        assign bram_rvalid = v1;
        assign bram_datao  = core_rdata;
    end
endmodule

// File: tb/tb_bram_sp_ctrl.sv
// tb_bram_sp_ctrl: scoreboard bench driving a read-first/latency-1 and a write-first/latency-2 instance
module tb_bram_sp_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bram_en = 1'b0;
    logic        bram_wen = 1'b0;
    logic [3:0]  bram_be = '0;
    logic [3:0]  bram_addr = '0;
    logic [31:0] bram_datai = '0;
    logic [31:0] datao1, datao2, datao3;
    logic        rv1, rv2, rv3, rdy1, rdy2, rdy3;
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    typedef struct {logic [31:0] d; int due;} exp_t;
    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e1, e2;
    logic [31:0] mm [16];
    logic [31:0] prev1 = '0;
    logic [31:0] prev2 = '0;

    bram_sp_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset(reset), .bram_en(bram_en), .bram_wen(bram_wen), .bram_be(bram_be),
        .bram_addr(bram_addr), .bram_datai(bram_datai), .bram_datao(datao1), .bram_rvalid(rv1), .bram_ready(rdy1));
    bram_sp_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2), .WRITE_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .reset(reset), .bram_en(bram_en), .bram_wen(bram_wen), .bram_be(bram_be),
        .bram_addr(bram_addr), .bram_datai(bram_datai), .bram_datao(datao2), .bram_rvalid(rv2), .bram_ready(rdy2));
    bram_sp_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .WRITE_MODE(0), .CLEAR_ON_RESET(0)) dut_c (
        .clk(clk), .reset(reset), .bram_en(bram_en), .bram_wen(bram_wen), .bram_be(bram_be),
        .bram_addr(bram_addr), .bram_datai(bram_datai), .bram_datao(datao3), .bram_rvalid(rv3), .bram_ready(rdy3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Return monitor: pops the scoreboards on every rvalid, checks data, arrival cycle and hold
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (rv1) begin
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL lat1_unexpected: rvalid with datao=%h at cycle %0d, required no rvalid", datao1, cyc);
                end else begin
                    e1 = q1.pop_front();
                    if (datao1 !== e1.d || cyc != e1.due) begin
                        fails++;
                        $display("FAIL lat1_return: got %h at cycle %0d, required %h at cycle %0d", datao1, cyc, e1.d, e1.due);
                    end
                end
            end else if (datao1 !== prev1) begin
                fails++;
                $display("FAIL lat1_hold: datao changed to %h without rvalid, required %h", datao1, prev1);
            end
            checks++;
            if (rv2) begin
                if (q2.size() == 0) begin
                    fails++;
                    $display("FAIL lat2_unexpected: rvalid with datao=%h at cycle %0d, required no rvalid", datao2, cyc);
                end else begin
                    e2 = q2.pop_front();
                    if (datao2 !== e2.d || cyc != e2.due) begin
                        fails++;
                        $display("FAIL lat2_return: got %h at cycle %0d, required %h at cycle %0d", datao2, cyc, e2.d, e2.due);
                    end
                end
            end else if (datao2 !== prev2) begin
                fails++;
                $display("FAIL lat2_hold: datao changed to %h without rvalid, required %h", datao2, prev2);
            end
        end
        prev1 = datao1;
        prev2 = datao2;
    end

    task automatic issue(input logic w, input logic [3:0] b, input logic [3:0] a, input logic [31:0] d,
                         input bit p1 = 1'b1, input bit p2 = 1'b1);
        logic [31:0] old, nw;
        old = mm[a];
        nw = old;
        for (int i = 0; i < 4; i++) if (b[i]) nw[i*8 +: 8] = d[i*8 +: 8];
        if (p1) q1.push_back('{old, cyc + 1});
        if (p2) q2.push_back('{w ? nw : old, cyc + 2});
        if (w) mm[a] = nw;
        bram_en = 1'b1;
        bram_wen = w;
        bram_be = b;
        bram_addr = a;
        bram_datai = d;
        @(posedge clk);
        #1;
        bram_en = 1'b0;
        bram_wen = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 10 && (q1.size() != 0 || q2.size() != 0); n++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!(rdy1 && rdy2) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 16; i++) mm[i] = '0;
    endtask

    task automatic test_reset();
        int n;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rdy1 !== 1'b0 || rdy2 !== 1'b0 || rdy3 !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b%b%b, required 001", rdy1, rdy2, rdy3);
        end
        checks++;
        if (rv1 !== 1'b0 || rv2 !== 1'b0 || datao1 !== 32'h0 || datao2 !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got rvalid %b%b datao %h %h, required 00 0 0", rv1, rv2, datao1, datao2);
        end
        reset = 1'b1;
        wait_ready(n);
        checks++;
        if (n != 16) begin
            fails++;
            $display("FAIL sweep_cycles: got %0d, required 16", n);
        end
    endtask

    task automatic test_clear();
        for (int a = 0; a < 16; a++) issue(1'b0, 4'h0, 4'(a), 32'h0);
        drain();
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL clear_pending: got %0d %0d, required 0 0", q1.size(), q2.size());
        end
    endtask

    task automatic test_latency();
        issue(1'b1, 4'hF, 4'h3, 32'hDEADBEEF);
        q1.push_back('{32'hDEADBEEF, cyc + 1});
        q2.push_back('{32'hDEADBEEF, cyc + 2});
        issue(1'b0, 4'h0, 4'h3, 32'h0, 1'b0, 1'b0);
        drain();
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL latency_pending: got %0d %0d, required 0 0", q1.size(), q2.size());
        end
    endtask

    task automatic test_byte_en();
        issue(1'b1, 4'hF, 4'h5, 32'h11223344);
        issue(1'b1, 4'b0101, 4'h5, 32'hAABBCCDD);
        q1.push_back('{32'h11BB33DD, cyc + 1});
        q2.push_back('{32'h11BB33DD, cyc + 2});
        issue(1'b0, 4'h0, 4'h5, 32'h0, 1'b0, 1'b0);
        drain();
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL byte_en_pending: got %0d %0d, required 0 0", q1.size(), q2.size());
        end
    endtask

    task automatic test_write_mode();
        issue(1'b1, 4'hF, 4'h9, 32'h0);
        q1.push_back('{32'h00000000, cyc + 1});
        q2.push_back('{32'h5A5A5A5A, cyc + 2});
        issue(1'b1, 4'hF, 4'h9, 32'h5A5A5A5A, 1'b0, 1'b0);
        q1.push_back('{32'h5A5A5A5A, cyc + 1});
        q2.push_back('{32'h5A5A5A5A, cyc + 2});
        issue(1'b1, 4'h0, 4'h9, 32'h12345678, 1'b0, 1'b0);
        q1.push_back('{32'h5A5A5A5A, cyc + 1});
        q2.push_back('{32'h5A5A5A5A, cyc + 2});
        issue(1'b0, 4'h0, 4'h9, 32'h0, 1'b0, 1'b0);
        drain();
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL write_mode_pending: got %0d %0d, required 0 0", q1.size(), q2.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 64; k++)
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
        drain();
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL stream_pending: got %0d %0d, required 0 0", q1.size(), q2.size());
        end
    endtask

    task automatic test_reset_sweep();
        int n;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bram_en = 1'b1;
        bram_wen = 1'b1;
        bram_be = 4'hF;
        bram_addr = 4'h0;
        bram_datai = 32'hFFFFFFFF;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (rdy1 !== 1'b0 || rv1 !== 1'b0 || datao1 !== 32'h0) begin
            fails++;
            $display("FAIL midsweep_reset: got ready=%b rvalid=%b datao=%h, required 0 0 0", rdy1, rv1, datao1);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_ready(n);
        bram_en = 1'b0;
        bram_wen = 1'b0;
        checks++;
        if (n != 16) begin
            fails++;
            $display("FAIL resweep_cycles: got %0d, required 16", n);
        end
        for (int a = 0; a < 16; a += 5) issue(1'b0, 4'h0, 4'(a), 32'h0);
        drain();
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL resweep_pending: got %0d %0d, required 0 0", q1.size(), q2.size());
        end
    endtask

    task automatic test_reset_inflight();
        issue(1'b1, 4'hF, 4'h2, 32'hCAFEF00D);
        issue(1'b0, 4'h0, 4'h2, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 4'h0, 4'h2, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checks++;
        if (rv1 !== 1'b0 || rv2 !== 1'b0 || datao1 !== 32'h0 || datao2 !== 32'h0) begin
            fails++;
            $display("FAIL inflight_kill: got rvalid %b%b datao %h %h, required 00 0 0", rv1, rv2, datao1, datao2);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (q1.size() != 0 || q2.size() != 0 || rdy1 !== 1'b0) begin
            fails++;
            $display("FAIL inflight_after: got pending %0d %0d ready %b, required 0 0 0", q1.size(), q2.size(), rdy1);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_latency();
        test_byte_en();
        test_write_mode();
        test_back_to_back();
        test_reset_sweep();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1);
    end
endmodule
